// File: rtl/sha3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sha3_pkg
// Description : Shared types and constants for the SHA3 sponge sequencer.
//               The types are the variant select, the sponge FSM states, the
//               rate lookup and the padding byte values.
// Revision    : 1.0 - initial release
// ============================================================================
package sha3_pkg;

    typedef enum logic [1:0] {
        SHA3_224 = 2'd0,
        SHA3_256 = 2'd1,
        SHA3_384 = 2'd2,
        SHA3_512 = 2'd3
    } sha3_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABSORB = 3'd1,
        ST_PAD    = 3'd2,
        ST_PERM   = 3'd3,
        ST_DONE   = 3'd4
    } sponge_st_t;

    localparam logic [7:0] PAD_DOMAIN = 8'h06;
    localparam logic [7:0] PAD_FINAL  = 8'h80;

    // Rate in 16-bit words: (1600 - 2*digest_bits) / 16
    function automatic logic [6:0] rate_words(input sha3_mode_t m);
        case (m)
            SHA3_224: rate_words = 7'd72;
            SHA3_256: rate_words = 7'd68;
            SHA3_384: rate_words = 7'd52;
            default:  rate_words = 7'd36;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sha3_pad_word.sv
`default_nettype none
// ============================================================================
// Module      : sha3_pad_word
// Description : Combinational word builder. It keeps the valid message bytes
//               and fills the remaining bytes with SHA3 padding. The domain
//               byte goes in the first free byte. The final bit is ORed into
//               the high byte of the last rate word once padding has begun.
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_pad_word
    import sha3_pkg::*;
(
    input  logic [15:0] data,
    input  logic [1:0]  keep,
    input  logic        pad_started,
    input  logic        is_rate_end,
    output logic [15:0] word,
    output logic        pad_started_next
);

    logic       w_b0_valid;
    logic       w_b1_valid;
    logic       w_dom_in_b0;
    logic [7:0] w_byte0;
    logic [7:0] w_byte1;

    // Byte 1 counts as message only when byte 0 is message too (keep=10 is not legal)
    always_comb begin
        w_b0_valid  = keep[0];
        w_b1_valid  = keep[0] & keep[1];
        w_dom_in_b0 = !w_b0_valid && !pad_started;
        w_byte0     = w_b0_valid ? data[7:0] : (pad_started ? 8'h00 : PAD_DOMAIN);
        w_byte1     = w_b1_valid ? data[15:8] :
                      ((pad_started || w_dom_in_b0) ? 8'h00 : PAD_DOMAIN);
        pad_started_next = pad_started | !w_b1_valid;
        // A full word at the rate end leaves no room, so the final bit waits for the next block
        if (is_rate_end && pad_started_next) begin
            w_byte1 = w_byte1 | PAD_FINAL;
        end
        word = {w_byte1, w_byte0};
    end

endmodule
`default_nettype wire

// File: rtl/sha3_sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sha3_sponge_ctrl
// Description : Sponge sequencer between a 16-bit message stream and a
//               Keccak-f[1600] core. It packs words into rate-block writes,
//               applies SHA3 padding, starts one permutation per block and
//               flags the finished digest.
//               Optional macro SHA3_ERR_CHECK_EN enables the sticky err flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sha3_sponge_ctrl
    import sha3_pkg::*;
#(
    parameter int IDX_W = 7
) (
    input  logic             ACLK,
    input  logic             ARESETn,
    input  logic [15:0]      s_data,
    input  logic [1:0]       s_keep,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    input  logic [1:0]       mode,
    output logic             k_wr_en,
    output logic [IDX_W-1:0] k_wr_idx,
    output logic [15:0]      k_wr_data,
    output logic             k_start,
    input  logic             k_done,
    output logic             hash_valid,
    input  logic             hash_ready,
    output logic [1:0]       hash_mode,
    output logic             err
);

    sponge_st_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             pad_started_q, pad_started_d;
    logic             final_q, final_d;       // block in flight completes the message
    logic             pend_pad_q, pend_pad_d; // a pure pad block must follow
    logic             started_q, started_d;   // k_start already issued for this block
    logic [1:0]       hash_mode_q, hash_mode_d;
    logic             wr_en_q, wr_en_d;
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [15:0]      wr_data_q, wr_data_d;
    logic             start_q, start_d;

    logic             w_absorbing;
    logic             w_accept;
    logic [IDX_W-1:0] w_idx;
    logic [IDX_W-1:0] w_last_idx;
    logic             w_at_end;
    sha3_mode_t       w_mode_sel;
    logic [15:0]      w_pad_data;
    logic [1:0]       w_pad_keep;
    logic             w_pad_in_started;
    logic [15:0]      w_pad_word;
    logic             w_pad_next;

    assign w_absorbing = (state_q == ST_IDLE) || (state_q == ST_ABSORB);
    assign s_ready     = ARESETn & w_absorbing;
    assign w_accept    = s_valid & s_ready;
    // The first word of a message always lands at index 0 with the live mode
    assign w_idx       = (state_q == ST_IDLE) ? '0 : idx_q;
    assign w_mode_sel  = (state_q == ST_IDLE) ? sha3_mode_t'(mode) : sha3_mode_t'(hash_mode_q);
    assign w_last_idx  = IDX_W'(rate_words(w_mode_sel) - 7'd1);
    assign w_at_end    = (w_idx == w_last_idx);

    // The pad slice sees the live word while absorbing and pure padding otherwise
    always_comb begin
        w_pad_data       = 16'h0000;
        w_pad_keep       = 2'b00;
        w_pad_in_started = pad_started_q;
        if (w_absorbing) begin
            w_pad_data       = s_data;
            w_pad_keep       = s_last ? s_keep : 2'b11;
            w_pad_in_started = 1'b0;
        end
    end

    sha3_pad_word u_pad (
        .data             (w_pad_data),
        .keep             (w_pad_keep),
        .pad_started      (w_pad_in_started),
        .is_rate_end      (w_at_end),
        .word             (w_pad_word),
        .pad_started_next (w_pad_next)
    );

    // Sponge sequencing: next state, block bookkeeping and core write requests
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        pad_started_d = pad_started_q;
        final_d       = final_q;
        pend_pad_d    = pend_pad_q;
        started_d     = started_q;
        hash_mode_d   = hash_mode_q;
        wr_en_d       = 1'b0;
        wr_idx_d      = wr_idx_q;
        wr_data_d     = wr_data_q;
        start_d       = 1'b0;
        case (state_q)
            ST_IDLE, ST_ABSORB: begin
                if (w_accept) begin
                    if (state_q == ST_IDLE) begin
                        hash_mode_d = mode;
                    end
                    wr_en_d   = 1'b1;
                    wr_idx_d  = w_idx;
                    wr_data_d = w_pad_word;
                    if (w_at_end) begin
                        state_d    = ST_PERM;
                        started_d  = 1'b0;
                        final_d    = s_last & w_pad_next;
                        pend_pad_d = s_last & !w_pad_next;
                    end else begin
                        idx_d         = w_idx + IDX_W'(1);
                        state_d       = s_last ? ST_PAD : ST_ABSORB;
                        pad_started_d = s_last & w_pad_next;
                    end
                end
            end
            ST_PAD: begin
                wr_en_d       = 1'b1;
                wr_idx_d      = idx_q;
                wr_data_d     = w_pad_word;
                pad_started_d = w_pad_next;
                if (w_at_end) begin
                    state_d    = ST_PERM;
                    started_d  = 1'b0;
                    final_d    = 1'b1;
                    pend_pad_d = 1'b0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_PERM: begin
                if (!started_q) begin
                    start_d   = 1'b1;
                    started_d = 1'b1;
                end else if (k_done) begin
                    idx_d = '0;
                    if (final_q) begin
                        state_d = ST_DONE;
                    end else if (pend_pad_q) begin
                        state_d       = ST_PAD;
                        pad_started_d = 1'b0;
                        pend_pad_d    = 1'b0;
                    end else begin
                        state_d = ST_ABSORB;
                    end
                end
            end
            ST_DONE: begin
                if (hash_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            pad_started_q <= 1'b0;
            final_q       <= 1'b0;
            pend_pad_q    <= 1'b0;
            started_q     <= 1'b0;
            hash_mode_q   <= 2'b00;
            wr_en_q       <= 1'b0;
            wr_idx_q      <= '0;
            wr_data_q     <= 16'h0000;
            start_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            pad_started_q <= pad_started_d;
            final_q       <= final_d;
            pend_pad_q    <= pend_pad_d;
            started_q     <= started_d;
            hash_mode_q   <= hash_mode_d;
            wr_en_q       <= wr_en_d;
            wr_idx_q      <= wr_idx_d;
            wr_data_q     <= wr_data_d;
            start_q       <= start_d;
        end
    end

    assign k_wr_en    = wr_en_q;
    assign k_wr_idx   = wr_idx_q;
    assign k_wr_data  = wr_data_q;
    assign k_start    = start_q;
    assign hash_valid = (state_q == ST_DONE);
    assign hash_mode  = hash_mode_q;

`ifdef SHA3_ERR_CHECK_EN
    logic err_q, err_d;

    // Sticky flag for partial non-last words and stray permutation-done pulses
    always_comb begin
        err_d = err_q;
        if (w_accept && !s_last && (s_keep != 2'b11)) begin
            err_d = 1'b1;
        end
        if (k_done && (state_q != ST_PERM)) begin
            err_d = 1'b1;
        end
    end

    // Error flag register, cleared only by reset
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha3_sponge_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sha3_sponge_ctrl
// Description : Self-checking bench for sha3_sponge_ctrl. A byte-level SHA3
//               padding model fills the expected write queue, and a monitor
//               collects the writes the DUT issues. A core stand-in answers
//               each k_start with k_done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sha3_sponge_ctrl;

    localparam int IDX_W = 7;
    localparam int LAT   = 6;

    logic             clk = 1'b0;
    logic             ARESETn;
    logic [15:0]      s_data;
    logic [1:0]       s_keep;
    logic             s_valid;
    logic             s_last;
    logic             s_ready;
    logic [1:0]       mode;
    logic             k_wr_en;
    logic [IDX_W-1:0] k_wr_idx;
    logic [15:0]      k_wr_data;
    logic             k_start;
    logic             k_done;
    logic             hash_valid;
    logic             hash_ready;
    logic [1:0]       hash_mode;
    logic             err;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int start_base = 0;
    int exp_starts = 0;
    int overlap_cnt = 0;
    logic [22:0] exp_q[$];
    logic [22:0] obs_q[$];
    logic [7:0]  msg[$];

    sha3_sponge_ctrl #(.IDX_W(IDX_W)) dut (
        .ACLK       (clk),
        .ARESETn    (ARESETn),
        .s_data     (s_data),
        .s_keep     (s_keep),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .mode       (mode),
        .k_wr_en    (k_wr_en),
        .k_wr_idx   (k_wr_idx),
        .k_wr_data  (k_wr_data),
        .k_start    (k_start),
        .k_done     (k_done),
        .hash_valid (hash_valid),
        .hash_ready (hash_ready),
        .hash_mode  (hash_mode),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Collect issued writes and permutation starts
    always @(negedge clk) begin
        if (k_wr_en === 1'b1) obs_q.push_back({k_wr_idx, k_wr_data});
        if (k_start === 1'b1) start_cnt = start_cnt + 1;
        if (k_wr_en === 1'b1 && k_start === 1'b1) overlap_cnt = overlap_cnt + 1;
    end

    // Keccak core stand-in: k_done LAT cycles after each k_start
    initial begin
        k_done = 1'b0;
        forever begin
            @(negedge clk);
            if (k_start === 1'b1) begin
                repeat (LAT) @(negedge clk);
                k_done = 1'b1;
                @(negedge clk);
                k_done = 1'b0;
            end
        end
    end

    function automatic int rate_w(input int md);
        case (md)
            0: rate_w = 72;
            1: rate_w = 68;
            2: rate_w = 52;
            default: rate_w = 36;
        endcase
    endfunction

    // Push the padded blocks of msg into exp_q, then stream msg into the DUT
    task automatic drive_msg(input int md, input bit gaps, input bit flip_mode);
        int rw, rb, n, plen, nw, tmo;
        logic [7:0] pb[$];
        rw = rate_w(md);
        rb = 2 * rw;
        n = msg.size();
        plen = (n / rb + 1) * rb;
        for (int i = 0; i < plen; i++) pb.push_back((i < n) ? msg[i] : 8'h00);
        pb[n] = pb[n] | 8'h06;
        pb[plen-1] = pb[plen-1] | 8'h80;
        for (int w = 0; w < plen / 2; w++) exp_q.push_back({7'(w % rw), pb[2*w+1], pb[2*w]});
        exp_starts = plen / rb;
        start_base = start_cnt;
        nw = (n == 0) ? 1 : (n + 1) / 2;
        mode = 2'(md);
        for (int w = 0; w < nw; w++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(negedge clk);
            end
            s_valid = 1'b1;
            s_last  = (w == nw - 1);
            s_data  = {(2*w+1 < n) ? msg[2*w+1] : 8'h00, (2*w < n) ? msg[2*w] : 8'h00};
            if (w == nw - 1) s_keep = (n == 0) ? 2'b00 : ((n % 2 == 1) ? 2'b01 : 2'b11);
            else             s_keep = 2'b11;
            tmo = 0;
            while (s_ready !== 1'b1 && tmo < 2000) begin
                @(negedge clk);
                tmo++;
            end
            checks++;
            if (s_ready !== 1'b1) begin
                errors++;
                $display("FAIL accept_timeout word %0d: s_ready=%b required 1", w, s_ready);
                break;
            end
            @(negedge clk);
            if (flip_mode) mode = 2'(md ^ 3);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_keep  = 2'b11;
        s_data  = 16'h0000;
    endtask

    // Wait for the digest, score the writes, optionally hold off, then release
    task automatic finish_msg(input string name, input int md, input int hold);
        int tmo;
        logic [22:0] e, o;
        tmo = 0;
        while (hash_valid !== 1'b1 && tmo < 5000) begin
            @(posedge clk);
            #1;
            tmo++;
        end
        checks++;
        if (hash_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s hash_valid_timeout: hash_valid=%b required 1", name, hash_valid);
        end else begin
            checks++;
            if (k_done !== 1'b1) begin
                errors++;
                $display("FAIL %s hash_valid_timing: k_done=%b at hash_valid rise required 1", name, k_done);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s write_count: got %0d required %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL %s write[%0d]: got idx=%0d data=%h required idx=%0d data=%h",
                         name, i, o[22:16], o[15:0], e[22:16], e[15:0]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (start_cnt - start_base != exp_starts) begin
            errors++;
            $display("FAIL %s k_start_count: got %0d required %0d", name, start_cnt - start_base, exp_starts);
        end
        checks++;
        if (hash_mode !== 2'(md)) begin
            errors++;
            $display("FAIL %s hash_mode: got %0d required %0d", name, hash_mode, md);
        end
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL %s start_write_overlap: got %0d required 0", name, overlap_cnt);
        end
        if (hold > 0) begin
            s_valid = 1'b1;
            s_data  = 16'hDEAD;
            s_keep  = 2'b11;
            s_last  = 1'b1;
            for (int c = 0; c < hold; c++) begin
                @(posedge clk);
                #1;
                checks++;
                if (hash_valid !== 1'b1 || s_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s hold cycle %0d: hash_valid=%b s_ready=%b required 1 0",
                             name, c, hash_valid, s_ready);
                end
            end
            s_valid = 1'b0;
            s_last  = 1'b0;
        end
        @(negedge clk);
        hash_ready = 1'b1;
        @(posedge clk);
        #1;
        hash_ready = 1'b0;
        checks++;
        if (hash_valid !== 1'b0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: hash_valid=%b s_ready=%b required 0 1", name, hash_valid, s_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL %s stray_write: got %0d writes required 0", name, obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({s_ready, k_wr_en, k_wr_idx, k_wr_data, k_start, hash_valid, hash_mode, err} !== '0) begin
            errors++;
            $display("FAIL reset_values: got %b required all zero",
                     {s_ready, k_wr_en, k_wr_idx, k_wr_data, k_start, hash_valid, hash_mode, err});
        end
        ARESETn = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1 || hash_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: s_ready=%b hash_valid=%b required 1 0", s_ready, hash_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_empty();
        msg.delete();
        drive_msg(0, 1'b0, 1'b0);
        finish_msg("empty_m0", 0, 0);
    endtask

    task automatic test_abc();
        msg.delete();
        msg.push_back(8'h61);
        msg.push_back(8'h62);
        msg.push_back(8'h63);
        drive_msg(1, 1'b0, 1'b0);
        finish_msg("abc_m1", 1, 0);
    endtask

    task automatic test_rate_boundary();
        msg.delete();
        for (int i = 0; i < 70; i++) msg.push_back(8'($urandom_range(0, 255)));
        msg.push_back(8'hAB);
        drive_msg(3, 1'b0, 1'b0);
        finish_msg("rate_boundary_m3", 3, 0);
    endtask

    task automatic test_pad_overflow();
        msg.delete();
        for (int i = 0; i < 72; i++) msg.push_back(8'($urandom_range(0, 255)));
        drive_msg(3, 1'b0, 1'b0);
        finish_msg("pad_overflow_m3", 3, 0);
    endtask

    task automatic test_multi_block();
        msg.delete();
        for (int i = 0; i < 211; i++) msg.push_back(8'($urandom_range(0, 255)));
        drive_msg(2, 1'b1, 1'b1);
        finish_msg("multi_block_m2", 2, 0);
    endtask

    task automatic test_backpressure();
        msg.delete();
        for (int i = 0; i < 5; i++) msg.push_back(8'($urandom_range(0, 255)));
        drive_msg(0, 1'b0, 1'b0);
        finish_msg("backpressure_m0", 0, 10);
    endtask

    task automatic test_back_to_back();
        msg.delete();
        for (int i = 0; i < 136; i++) msg.push_back(8'($urandom_range(0, 255)));
        drive_msg(1, 1'b1, 1'b0);
        finish_msg("b2b_first_m1", 1, 0);
        msg.delete();
        msg.push_back(8'h5A);
        drive_msg(0, 1'b0, 1'b0);
        finish_msg("b2b_second_m0", 0, 0);
    endtask

    task automatic test_reset_mid();
        int tmo;
        msg.delete();
        for (int i = 0; i < 10; i++) msg.push_back(8'($urandom_range(0, 255)));
        drive_msg(3, 1'b0, 1'b0);
        tmo = 0;
        while (k_start !== 1'b1 && tmo < 500) begin
            @(posedge clk);
            #1;
            tmo++;
        end
        checks++;
        if (k_start !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid k_start_timeout: k_start=%b required 1", k_start);
        end
        @(negedge clk);
        #1;
        ARESETn = 1'b0;
        #1;
        checks++;
        if ({s_ready, k_wr_en, k_wr_idx, k_wr_data, k_start, hash_valid, hash_mode, err} !== '0) begin
            errors++;
            $display("FAIL reset_mid values: got %b required all zero",
                     {s_ready, k_wr_en, k_wr_idx, k_wr_data, k_start, hash_valid, hash_mode, err});
        end
        repeat (2) @(negedge clk);
        ARESETn = 1'b1;
        repeat (LAT + 3) @(posedge clk);
        #1;
        checks++;
        if (hash_valid !== 1'b0 || s_ready !== 1'b1 || k_start !== 1'b0 || k_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid stale_done: hash_valid=%b s_ready=%b k_start=%b k_wr_en=%b required 0 1 0 0",
                     hash_valid, s_ready, k_start, k_wr_en);
        end
        exp_q.delete();
        obs_q.delete();
        @(negedge clk);
        msg.delete();
        drive_msg(2, 1'b0, 1'b0);
        finish_msg("reset_mid_empty_m2", 2, 0);
    endtask

    initial begin
        ARESETn    = 1'b0;
        s_data     = 16'h0000;
        s_keep     = 2'b11;
        s_valid    = 1'b0;
        s_last     = 1'b0;
        mode       = 2'b00;
        hash_ready = 1'b0;
        test_reset();
        test_empty();
        test_abc();
        test_rate_boundary();
        test_pad_overflow();
        test_multi_block();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sha3_sponge_ctrl.md
# sha3_sponge_ctrl

Sponge sequencer placed between the 16-bit AXI-Stream message input and the shared Keccak-f[1600] permutation core of the SHA3 engine. It packs message words into rate-block writes and applies SHA3 padding (0x06 … 0x80) per the selected variant. It issues one permutation per block and raises a digest-ready handshake once the final permutation completes. The digest itself is read by the consumer directly from the core's 5×5×64 state.

## Interface
- `IDX_W`, 7: rate word-index width. Covers at most 72 words of 16 bits.
- `ACLK` in 1: clock, rising edge.
- `ARESETn` in 1: asynchronous active-low reset.
- `s_data` in 16: message word. Byte 0 is `[7:0]`, consistent with Keccak's little-endian lanes.
- `s_keep` in 2: valid bytes, honoured on the last word only. Encodings: `00` none, `01` byte 0, `11` both.
- `s_valid` in 1: word valid.
- `s_last` in 1: final word of the message.
- `s_ready` out 1: word accepted when `s_valid & s_ready`.
- `mode` in 2: variant select. `0` SHA3-224, `1` SHA3-256, `2` SHA3-384, `3` SHA3-512. Sampled on the first accepted word.
- `k_wr_en` out 1: write a rate word into the core's block buffer.
- `k_wr_idx` out `IDX_W`: 16-bit word index within the rate.
- `k_wr_data` out 16: word to write.
- `k_start` out 1: one-cycle pulse. The core XORs the block into the state and permutes.
- `k_done` in 1: one-cycle pulse when the permutation is finished.
- `hash_valid` out 1: digest in the core state is final.
- `hash_ready` in 1: consumer has taken the digest.
- `hash_mode` out 2: latched mode of the finished digest.
- `err` out 1: sticky protocol error (see Configuration).

## Operation
- Rate in words per mode: 72 / 68 / 52 / 36, written R below.
- States: IDLE, ABSORB, PAD, PERM, DONE.
- **IDLE:** `s_ready=1`. The first accepted word latches `mode` into `hash_mode`, clears the word counter `idx`, processes the word as in ABSORB, and moves to ABSORB (or PAD/PERM if `s_last`).
- **ABSORB:** `s_ready=1`. Each accepted non-last word is written at `idx`, then `idx++`.
  - `idx` reaching R with more data to come → PERM.
- **Last word at `idx`:** bytes beyond `s_keep` are replaced by padding.
  - 0x06 goes in the first free byte, and subsequent words are zero.
  - 0x80 is ORed into byte 1 of word R-1.
  - Overlap at the same byte gives 0x86.
  - `keep=11` at `idx=R-1` leaves no room. The block is sent to PERM full, and the next block is pure pad: word 0 = 0x0006, word R-1 = 0x8000, and all other words are zero.
  - `keep=00` means the word contributes no message bytes.
- **PAD:** `s_ready=0`. Writes one word per cycle through `idx=R-1`; every rate word is written each block. Then → PERM.
- **PERM:** `s_ready=0`. `k_start` pulses on entry, then the block waits for `k_done`.
  - Intermediate block: → ABSORB with `idx=0`.
  - Pending pad block: → PAD with `idx=0`.
  - Final block: → DONE.
- **DONE:** `hash_valid=1` until `hash_valid & hash_ready`, then → IDLE.
- Ignored inputs:
  - `k_done` outside PERM is ignored.
  - `mode` changes after the first word are ignored.
  - `s_*` is ignored while `s_ready=0`.

## Timing
- Reset values:
  - State IDLE, `s_ready=0` during reset.
  - `k_wr_en=0`, `k_wr_idx=0`, `k_wr_data=0`, `k_start=0`.
  - `hash_valid=0`, `hash_mode=0`, `err=0`.
- `s_ready` is combinational from state, and is 1 in IDLE/ABSORB after reset release.
- `k_wr_*` are registered: the write appears the cycle after acceptance.
- `k_start` is registered. It is high in the cycle after the final `k_wr_en` of the block, so it never coincides with a write.
- PAD issues writes on consecutive cycles with no gaps.
- `hash_valid` rises the cycle after `k_done` of the final block.
- Reset mid-operation (any state) returns to IDLE immediately. A `k_done` in flight is discarded.
- Throughput: one word per cycle while absorbing, plus permutation latency plus one cycle per block.

## Configuration
- `SHA3_ERR_CHECK_EN` defined:
  - `err` sets when a non-last word is accepted with `s_keep != 2'b11`, or when `k_done` arrives outside PERM.
  - `err` clears only on reset.
  - Data handling is unchanged.
- `SHA3_ERR_CHECK_EN` undefined: `err` is tied to 0, and `s_keep` is not examined on non-last words.

## Structure
- `sha3_pkg` holds:
  - enum `sha3_mode_t` (SHA3_224/256/384/512).
  - state enum `sponge_st_t`.
  - function `rate_words(sha3_mode_t)`.
  - constants `PAD_DOMAIN = 8'h06` and `PAD_FINAL = 8'h80`.
- One combinational sub-module, `sha3_pad_word`, takes (`data`, `keep`, `pad_started`, `is_rate_end`) and returns (`word`, `pad_started_next`).

## Test plan
- **Empty message, mode 0:** `keep=00`, `last` at word 0 → writes idx0=0x0006, idx1..70=0x0000, idx71=0x8000; one `k_start`; `hash_valid` after `k_done`; `hash_mode=0`.
- **"abc", mode 1:** words 0x6261 (`keep=11`) then 0x0063 (`keep=01`, `last`) → idx0=0x6261, idx1=0x0663, idx67=0x8000, one permutation.
- **Mode 3, rate boundary, single byte:** 35 full words, then `last` `keep=01` data 0x00AB at idx35 → idx35=0x86AB; exactly one `k_start`.
- **Mode 3, pad overflow:** 36 full words, `last` `keep=11` → two `k_start`s; second block idx0=0x0006, idx35=0x8000, others zero.
- **Digest backpressure:** `hash_ready=0` for 10 cycles → `hash_valid` stays high and `s_ready=0`; `hash_ready=1` → IDLE next cycle.
- **Reset mid-operation:** `ARESETn` low during PERM → all outputs at reset values. A following empty mode-2 message produces `k_wr_idx` 51 = 0x8000.
